led_frame_tx: RTL and testbench

Serializer stage directly downstream of the string/wave generator. It accepts one 32-bit APA102-style frame per handshake: a start frame, an LED frame built from blue/green/red bytes, or an end frame. It shifts the frame MSB-first onto `mosi`/`sck` toward the LED strip and holds `led_frame_tx_busy` high until the last bit's clock pulse has completed.

---
 rtl/led_frame_tx.sv | 132 +++++++++++++
 tb/tb_led_frame_tx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_tx.sv
// APA102-style frame serializer: accepts one 32-bit start/LED/end frame per
// handshake and shifts it MSB-first onto mosi/sck with a programmable SCK rate.
module led_frame_tx #(
    parameter int unsigned SCK_DIV           = 2,
    parameter logic [4:0]  GLOBAL_BRIGHTNESS = 5'd31
) (
    input  logic       led_frame_tx_clk,
    input  logic       led_frame_tx_reset,
    input  logic [7:0] blue_input,
    input  logic [7:0] green_input,
    input  logic [7:0] red_input,
    input  logic [1:0] type_input,
    input  logic       led_frame_tx_start,
    output logic       led_frame_tx_busy,
    output logic       mosi,
    output logic       sck
);

    // Handshake: a request is taken on any cycle where led_frame_tx_start is
    // high and led_frame_tx_busy is low; requests while busy are dropped.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        NOOP = 2'd3
    } state_t;

    localparam logic [7:0] HALF_LAST = 8'(SCK_DIV - 1);
    localparam logic [4:0] BIT_LAST  = 5'd31;

    state_t      state;
    state_t      state_next;
    logic [7:0]  half_cnt;
    logic [4:0]  bit_cnt;
    logic [31:0] shift_reg;
    logic [31:0] frame_word;
    logic        accept;
    logic        half_done;

    assign accept    = led_frame_tx_start && (state == IDLE);
    assign half_done = (half_cnt == HALF_LAST);

    always_comb begin
        frame_word = 32'h0000_0000;
        case (type_input)
            2'd0:    frame_word = 32'h0000_0000;
            2'd1:    frame_word = {3'b111, GLOBAL_BRIGHTNESS, blue_input, green_input, red_input};
            2'd2:    frame_word = 32'hFFFF_FFFF;
            default: frame_word = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge led_frame_tx_clk) begin
        if (led_frame_tx_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next        = state;
        led_frame_tx_busy = 1'b0;
        sck               = 1'b0;
        mosi              = 1'b0;
        case (state)
            IDLE: begin
                if (led_frame_tx_start) begin
                    state_next = (type_input == 2'd3) ? NOOP : LOW;
                end
            end
            LOW: begin
                led_frame_tx_busy = 1'b1;
                mosi              = shift_reg[31];
                if (half_done) begin
                    state_next = HIGH;
                end
            end
            HIGH: begin
                led_frame_tx_busy = 1'b1;
                sck               = 1'b1;
                mosi              = shift_reg[31];
                if (half_done) begin
                    state_next = (bit_cnt == BIT_LAST) ? IDLE : LOW;
                end
            end
            NOOP: begin
                led_frame_tx_busy = 1'b1;
                state_next        = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The shift only happens at the end of HIGH so mosi moves while sck is low.
    always_ff @(posedge led_frame_tx_clk) begin
        if (led_frame_tx_reset) begin
            half_cnt  <= 8'd0;
            bit_cnt   <= 5'd0;
            shift_reg <= 32'h0000_0000;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift_reg <= frame_word;
                        half_cnt  <= 8'd0;
                        bit_cnt   <= 5'd0;
                    end
                end
                LOW: begin
                    half_cnt <= half_done ? 8'd0 : half_cnt + 8'd1;
                end
                HIGH: begin
                    if (half_done) begin
                        half_cnt <= 8'd0;
                        if (bit_cnt != BIT_LAST) begin
                            shift_reg <= {shift_reg[30:0], 1'b0};
                            bit_cnt   <= bit_cnt + 5'd1;
                        end
                    end else begin
                        half_cnt <= half_cnt + 8'd1;
                    end
                end
                default: begin
                    half_cnt <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_frame_tx.sv
// Bench for led_frame_tx: two instances (SCK_DIV=2/brightness 31 and
// SCK_DIV=1/brightness 0), random frames, reset abort and back-to-back cases.
module tb_led_frame_tx;

    localparam int DIV0 = 2;
    localparam int DIV1 = 1;
    localparam logic [4:0] GB0 = 5'd31;
    localparam logic [4:0] GB1 = 5'd0;

    typedef struct packed {
        logic [31:0] word;
        logic [7:0]  edges;
        logic [15:0] len;
        logic        noop;
        logic        abort;
    } exp_t;

    logic       clk = 1'b0;
    logic [1:0] rst = 2'b11;
    logic [1:0] start = 2'b00;
    logic [7:0] blue = 8'd0;
    logic [7:0] green = 8'd0;
    logic [7:0] red = 8'd0;
    logic [1:0] typ = 2'd0;
    logic [1:0] busy;
    logic [1:0] sck;
    logic [1:0] mosi;

    int   vectors = 0;
    int   miscompares = 0;
    int   tick = 0;
    int   free_edge [2];
    exp_t q0 [$];
    exp_t q1 [$];

    always #5 clk = ~clk;

    led_frame_tx #(.SCK_DIV(DIV0), .GLOBAL_BRIGHTNESS(GB0)) dut0 (
        .led_frame_tx_clk(clk), .led_frame_tx_reset(rst[0]),
        .blue_input(blue), .green_input(green), .red_input(red),
        .type_input(typ), .led_frame_tx_start(start[0]),
        .led_frame_tx_busy(busy[0]), .mosi(mosi[0]), .sck(sck[0])
    );

    led_frame_tx #(.SCK_DIV(DIV1), .GLOBAL_BRIGHTNESS(GB1)) dut1 (
        .led_frame_tx_clk(clk), .led_frame_tx_reset(rst[1]),
        .blue_input(blue), .green_input(green), .red_input(red),
        .type_input(typ), .led_frame_tx_start(start[1]),
        .led_frame_tx_busy(busy[1]), .mosi(mosi[1]), .sck(sck[1])
    );

    function automatic int div_of(input int idx);
        return (idx == 0) ? DIV0 : DIV1;
    endfunction

    // Reference frame contents straight from the frame format rules.
    function automatic logic [31:0] model_word(input int idx, input logic [1:0] t,
                                               input logic [7:0] b, input logic [7:0] g,
                                               input logic [7:0] r);
        logic [4:0] gb;
        gb = (idx == 0) ? GB0 : GB1;
        case (t)
            2'd1:    return {3'b111, gb, b, g, r};
            2'd2:    return 32'hFFFF_FFFF;
            default: return 32'h0000_0000;
        endcase
    endfunction

    task automatic check(input int idx, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic push_exp(input int idx, input exp_t x);
        if (idx == 0) q0.push_back(x);
        else q1.push_back(x);
    endtask

    task automatic pop_exp(input int idx, output exp_t x, output bit ok);
        ok = 1'b0;
        x  = '0;
        if (idx == 0 && q0.size() > 0) begin x = q0.pop_front(); ok = 1'b1; end
        if (idx == 1 && q1.size() > 0) begin x = q1.pop_front(); ok = 1'b1; end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        tick++;
    endtask

    // Drives a one-cycle request; the model decides whether it is accepted.
    task automatic issue(input int idx, input logic [1:0] t, input logic [7:0] b,
                         input logic [7:0] g, input logic [7:0] r);
        int   e;
        exp_t x;
        typ = t; blue = b; green = g; red = r;
        start[idx] = 1'b1;
        e = tick + 1;
        if (rst[idx] == 1'b0 && e >= free_edge[idx]) begin
            x.word  = model_word(idx, t, b, g, r);
            x.edges = (t == 2'd3) ? 8'd0 : 8'd32;
            x.len   = (t == 2'd3) ? 16'd1 : 16'(64 * div_of(idx));
            x.noop  = (t == 2'd3);
            x.abort = 1'b0;
            push_exp(idx, x);
            free_edge[idx] = e + ((t == 2'd3) ? 2 : 64 * div_of(idx) + 1);
        end
        step();
        start[idx] = 1'b0;
        blue = 8'hAA; green = 8'hAA; red = 8'hAA;
        typ = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_free(input int idx);
        while (tick + 1 < free_edge[idx]) step();
    endtask

    task automatic do_reset(input int idx, input int n, input int exp_edges);
        exp_t x;
        rst[idx] = 1'b1;
        if (tick + 1 < free_edge[idx]) begin
            if (idx == 0) x = q0.pop_back(); else x = q1.pop_back();
            x.abort = 1'b1;
            x.edges = 8'(exp_edges);
            push_exp(idx, x);
        end
        repeat (n) step();
        rst[idx] = 1'b0;
        free_edge[idx] = tick + 1;
    endtask

    task automatic wait_rises(input int idx, input int n);
        int  rises;
        logic p;
        rises = 0;
        p = sck[idx];
        for (int i = 0; i < 4000 && rises < n; i++) begin
            step();
            if (sck[idx] && !p) rises++;
            p = sck[idx];
        end
        check(idx, "sck_rise_wait", 32'(rises), 32'(n));
    endtask

    // Monitor: rebuilds each frame from the pins and compares with the queue.
    task automatic mon(input int idx);
        bit          in_frame = 1'b0;
        logic        p_sck = 1'b0;
        logic        p_mosi = 1'b0;
        logic        p_rst = 1'b1;
        int          len = 0;
        int          edges = 0;
        logic [31:0] word = 32'h0;
        exp_t        x;
        bit          ok;
        forever begin
            @(negedge clk);
            if (p_rst) begin
                check(idx, "reset_outputs", 32'({busy[idx], sck[idx], mosi[idx]}), 32'h0);
                if (in_frame) begin
                    pop_exp(idx, x, ok);
                    check(idx, "abort_expected", 32'(ok), 32'h1);
                    check(idx, "abort_flag", 32'(x.abort), 32'h1);
                    check(idx, "abort_edges", 32'(edges), 32'(x.edges));
                    in_frame = 1'b0;
                end
            end else if (in_frame) begin
                if (busy[idx]) begin
                    len++;
                    if (sck[idx] && !p_sck) begin
                        edges++;
                        word = {word[30:0], mosi[idx]};
                    end
                    if (sck[idx]) check(idx, "mosi_stable_high", 32'(mosi[idx]), 32'(p_mosi));
                end else begin
                    pop_exp(idx, x, ok);
                    check(idx, "frame_expected", 32'(ok), 32'h1);
                    check(idx, "busy_len", 32'(len), 32'(x.len));
                    check(idx, "sck_edges", 32'(edges), 32'(x.edges));
                    check(idx, "not_aborted", 32'(x.abort), 32'h0);
                    if (!x.noop) check(idx, "frame_word", word, x.word);
                    check(idx, "end_idle", 32'({sck[idx], mosi[idx]}), 32'h0);
                    in_frame = 1'b0;
                end
            end else if (busy[idx] === 1'b1) begin
                in_frame = 1'b1;
                len = 1;
                edges = 0;
                word = 32'h0;
                check(idx, "first_cycle_sck", 32'(sck[idx]), 32'h0);
            end else begin
                check(idx, "idle_outputs", 32'({busy[idx], sck[idx], mosi[idx]}), 32'h0);
            end
            p_rst  = rst[idx];
            p_sck  = sck[idx];
            p_mosi = mosi[idx];
        end
    endtask

    initial mon(0);
    initial mon(1);

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        free_edge[0] = 0;
        free_edge[1] = 0;
        repeat (2) step();
        rst = 2'b00;
        free_edge[0] = tick + 1;
        free_edge[1] = tick + 1;

        // dut0: START, LED with ignored mid-frame request, END then back-to-back LED
        issue(0, 2'd0, 8'd0, 8'd0, 8'd0);
        wait_free(0);
        issue(0, 2'd1, 8'h12, 8'h34, 8'h56);
        repeat (20) step();
        issue(0, 2'd1, 8'hAA, 8'hAA, 8'hAA);
        wait_free(0);
        issue(0, 2'd2, 8'd0, 8'd0, 8'd0);
        wait_free(0);
        issue(0, 2'd1, 8'd0, 8'd0, 8'd0);
        wait_free(0);

        // dut0: reset after the 10th sck rise, then a full START frame
        issue(0, 2'd1, 8'(($urandom_range(0, 100))), 8'd77, 8'd5);
        wait_rises(0, 10);
        do_reset(0, 2, 10);
        repeat (3) step();
        issue(0, 2'd0, 8'd0, 8'd0, 8'd0);
        wait_free(0);

        for (int i = 0; i < 20; i++) begin
            issue(0, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 100)),
                  8'($urandom_range(0, 100)), 8'($urandom_range(0, 100)));
            repeat ($urandom_range(0, 140)) step();
        end
        wait_free(0);

        // dut1: END + back-to-back zero LED (brightness 0), no-op, random
        issue(1, 2'd2, 8'd0, 8'd0, 8'd0);
        wait_free(1);
        issue(1, 2'd1, 8'd0, 8'd0, 8'd0);
        wait_free(1);
        issue(1, 2'd3, 8'd9, 8'd9, 8'd9);
        wait_free(1);
        issue(1, 2'd1, 8'd100, 8'd50, 8'd1);
        wait_free(1);
        for (int i = 0; i < 20; i++) begin
            issue(1, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 100)),
                  8'($urandom_range(0, 100)), 8'($urandom_range(0, 100)));
            repeat ($urandom_range(0, 70)) step();
        end
        wait_free(1);

        for (int i = 0; i < 400 && (q0.size() != 0 || q1.size() != 0); i++) step();
        check(0, "queue_drained", 32'(q0.size()), 32'h0);
        check(1, "queue_drained", 32'(q1.size()), 32'h0);
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
